macro_fetch: RTL

MACRO_FETCH -- requirements
Module: macro_fetch

---
 rtl/macro_fetch_if.sv | 26 ++
 rtl/macro_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/macro_fetch_if.sv
// Macroinstruction fetch bus: consumer request side, memory read side and
// the fetched-instruction result, bundled for the fetch core.
interface macro_fetch_if;
  logic [25:0] lc;
  logic        needfetch;
  logic        flush;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [15:0] mir;
  logic        mir_valid;
  logic        busy;

  // Fetch unit side: drives memory requests and the fetched instruction.
  modport master (
    input  lc, needfetch, flush, mem_ack, mem_data,
    output mem_req, mem_addr, mir, mir_valid, busy
  );

  // Environment side: consumer plus memory.
  modport slave (
    output lc, needfetch, flush, mem_ack, mem_data,
    input  mem_req, mem_addr, mir, mir_valid, busy
  );
endinterface

// File: rtl/macro_fetch.sv
// Macroinstruction fetch unit with a one-word buffer. Hits are served in one
// cycle from the buffer; misses issue a word read and return the selected
// halfword when the memory acknowledges. A flush during an outstanding read
// lets the read complete but drops its data.
module macro_fetch_core (
  input  logic         clk,
  input  logic         rst_n,
  macro_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic        hsel_q, hsel_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [23:0] buf_tag_q, buf_tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] mir_q, mir_d;
  logic        mir_valid_q, mir_valid_d;

  logic        accept;
  logic        hit;
  logic        unused_lc0;

  // Byte-select bit of the location counter carries no meaning here.
  assign unused_lc0 = bus.lc[0];

  // A request is new only when we are idle and not in the cycle of the
  // previous result pulse (the consumer still holds needfetch then).
  assign accept = (state_q == IDLE) && bus.needfetch && !mir_valid_q;
  assign hit    = accept && !bus.flush && buf_valid_q &&
                  (buf_tag_q == bus.lc[25:2]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit) state_d = REQ;
      REQ: begin
        if (bus.mem_ack)    state_d = IDLE;
        else if (bus.flush) state_d = DISCARD;
      end
      DISCARD: if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; registered datapath values pass straight out.
  always_comb begin
    bus.mem_req   = (state_q != IDLE);
    bus.busy      = (state_q != IDLE);
    bus.mem_addr  = addr_q;
    bus.mir       = mir_q;
    bus.mir_valid = mir_valid_q;
  end

  // Datapath next values: buffer fill, request address capture, result.
  always_comb begin
    addr_d      = addr_q;
    hsel_d      = hsel_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
    mir_d       = mir_q;
    mir_valid_d = 1'b0;

    if (bus.flush) buf_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          mir_valid_d = 1'b1;
          mir_d       = bus.lc[1] ? buf_data_q[31:16] : buf_data_q[15:0];
        end else if (accept) begin
          addr_d = bus.lc[25:2];
          hsel_d = bus.lc[1];
        end
      end
      REQ: begin
        // An ack coinciding with flush is dropped; the flush above has
        // already invalidated the buffer.
        if (bus.mem_ack && !bus.flush) begin
          buf_data_d  = bus.mem_data;
          buf_tag_d   = addr_q;
          buf_valid_d = 1'b1;
          mir_d       = hsel_q ? bus.mem_data[31:16] : bus.mem_data[15:0];
          mir_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      hsel_q      <= 1'b0;
      buf_data_q  <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      mir_q       <= '0;
      mir_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      hsel_q      <= hsel_d;
      buf_data_q  <= buf_data_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
      mir_q       <= mir_d;
      mir_valid_q <= mir_valid_d;
    end
  end
endmodule

// Top level with flat ports; the bus is bundled internally for the core.
module macro_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [25:0] lc,
  input  logic        needfetch,
  input  logic        flush,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [15:0] mir,
  output logic        mir_valid,
  output logic        busy
);
  macro_fetch_if u_bus ();

  assign u_bus.lc        = lc;
  assign u_bus.needfetch = needfetch;
  assign u_bus.flush     = flush;
  assign u_bus.mem_ack   = mem_ack;
  assign u_bus.mem_data  = mem_data;
  assign mem_req         = u_bus.mem_req;
  assign mem_addr        = u_bus.mem_addr;
  assign mir             = u_bus.mir;
  assign mir_valid       = u_bus.mir_valid;
  assign busy            = u_bus.busy;

  macro_fetch_core u_core (
    .clk   (clk),
    .rst_n (reset_n),
    .bus   (u_bus.master)
  );
endmodule
